round_sequencer: RTL and testbench
==================================

# round_sequencer

Central round controller for the pattern-memory game. It takes a valid level from the level selector and runs exactly NUM_ROUNDS rounds. Each round clears the round-local submodules, then starts the pattern generator, then the LED pattern printer, then the button input trimmer, and then judges the result. It keeps the round and answer counters, inserts a fixed gap between rounds, and at game end publishes the final score to the 7-segment printer. All round sequencing lives in this one FSM.

## Interface
Parameters:
- NUM_ROUNDS, 10: rounds per game (1..15).
- GAP_CYCLES, 500: idle clk cycles between rounds (0.5 s at 1 kHz); must be ≥1.
- SCORE_STEP, 10: points per correct round; SCORE_STEP*NUM_ROUNDS ≤ 127.

Ports:
- clk  in  1  system clock (1 kHz game clock).
- rst  in  1  synchronous active-low reset; one clock; all state updates on posedge clk.
- level_valid  in  1  level selector finished (level-held).
- level  in  3  one-hot level: 001, 010 or 100.
- gen_done  in  1  pattern generator done (level-held until sub_rst_n).
- print_done  in  1  pattern printer done (level-held).
- trim_done  in  1  input trimmer done (level-held).
- round_win  in  1  combinational pattern-vs-input compare result.
- sub_rst_n  out  1  active-low round-local clear for generator, printer and trimmer.
- gen_start  out  1  one-cycle start pulse to the pattern generator.
- print_start  out  1  one-cycle start pulse to the printer.
- trim_enable  out  1  held high while input is accepted.
- level_q  out  3  level latched at game start.
- round_count  out  5  completed rounds.
- answer_count  out  4  correctly answered rounds.
- score  out  7  final score, valid when game_end=1.
- game_end  out  1  high after the last round until reset.

## Operation
- States, with transitions:
  - IDLE: wait until level_valid=1 and level is exactly one-hot. Latch level_q, go to CLR. Any non-one-hot level keeps the block in IDLE.
  - CLR: sub_rst_n=0 for exactly 1 cycle, then go to GEN.
  - GEN: gen_start=1 on the entry cycle only. Leave when gen_done=1, sampled from the cycle after the pulse onward; go to SHOW.
  - SHOW: print_start=1 on the entry cycle only. Same done-sampling rule with print_done; go to INPUT.
  - INPUT: trim_enable=1 for the whole state. Go to JUDGE when trim_done=1.
  - JUDGE: spend 2 cycles (settle, then sample).
    - On the sample cycle: round_count += 1 and answer_count += round_win.
    - If the new round_count == NUM_ROUNDS, go to DONE; otherwise go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to CLR.
  - DONE: score <= SCORE_STEP*answer_count, registered once on entry. game_end=1. Stay in DONE until rst.
- Any done input that is high on a start-pulse cycle is stale and is ignored.
- level and level_valid changes after IDLE are ignored. level_q is held for the whole game.
- Counters never wrap: round_count stops at NUM_ROUNDS and answer_count ≤ round_count.
- Outside CLR, sub_rst_n=1. Outside their active states, gen_start, print_start and trim_enable are 0.

## Timing
- Reset values:
  - state=IDLE.
  - sub_rst_n=1, gen_start=0, print_start=0, trim_enable=0.
  - level_q=000, round_count=0, answer_count=0, score=0, game_end=0.
- rst=0 in any state, including mid-INPUT or mid-GAP, forces the reset values at the next posedge. No partial round is counted.
- All outputs are registered.
- Start of game: IDLE→CLR takes 1 cycle after the qualifying edge. gen_start is asserted 2 cycles after level_valid is sampled high.
- Handoffs:
  - done sampled high → next start pulse on the following cycle (1-cycle latency per handoff).
  - trim_done high → counters update 2 cycles later.
- Round-to-round: the cycle after the JUDGE sample cycle begins GAP. The next CLR comes GAP_CYCLES cycles later.
- game_end and score both become valid on the cycle after the final JUDGE sample.
- A done input that is already held high when its wait state is entered counts only from the cycle after the pulse, giving a minimum 1-cycle dwell.

## Test plan
- Full game, all wins, level=010, with each done raised 3 cycles after its start: after 10 rounds round_count=10, answer_count=10, score=100, game_end=1, and exactly 10 gen_start pulses.
- Mixed results: round_win=1 in rounds 1, 4 and 7 only → answer_count=3 and score=30. Each sub_rst_n low pulse is exactly 1 cycle, and there are 10 of them.
- Invalid level 011 or 000 with level_valid=1 → stays in IDLE, with no sub_rst_n and no gen_start. Then level=001 → CLR on the next edge and level_q=001.
- Stale done: hold gen_done=1 through CLR and into GEN → GEN still dwells at least 1 cycle past the gen_start pulse before moving to SHOW.
- Gap timing, GAP_CYCLES=5 → exactly 5 cycles from the end of JUDGE to the sub_rst_n low cycle.
- Reset mid-INPUT in round 4 → next cycle every output is at its reset value, round_count=0, and a new game starts cleanly from IDLE.

Source files
------------

// File: rtl/round_sequencer.sv
// Round controller for the pattern-memory game: sequences clear, generate,
// show, input and judge for each round, then publishes the final score.
module round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int GAP_CYCLES = 500,
    parameter int SCORE_STEP = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_valid,
    input  logic [2:0] level,
    input  logic       gen_done,
    input  logic       print_done,
    input  logic       trim_done,
    input  logic       round_win,
    output logic       sub_rst_n,
    output logic       gen_start,
    output logic       print_start,
    output logic       trim_enable,
    output logic [2:0] level_q,
    output logic [4:0] round_count,
    output logic [3:0] answer_count,
    output logic [6:0] score,
    output logic       game_end
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_GEN,
        S_SHOW,
        S_INPUT,
        S_SETTLE,
        S_SAMPLE,
        S_GAP,
        S_DONE
    } state_e;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [4:0] ROUNDS = 5'(NUM_ROUNDS);
    localparam logic [6:0] STEP = 7'(SCORE_STEP);

    state_e state_q, state_d;

    logic [GW-1:0] gap_q, gap_d;
    logic          sub_rst_n_q, sub_rst_n_d;
    logic          gen_start_q, gen_start_d;
    logic          print_start_q, print_start_d;
    logic          trim_enable_q, trim_enable_d;
    logic          game_end_q, game_end_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [4:0]    round_q, round_d;
    logic [3:0]    answer_q, answer_d;
    logic [6:0]    score_q, score_d;
    logic          level_ok;
    logic          last_round;

    assign level_ok = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);
    assign last_round = (round_q + 5'd1) >= ROUNDS;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            gap_q         <= '0;
            sub_rst_n_q   <= 1'b1;
            gen_start_q   <= 1'b0;
            print_start_q <= 1'b0;
            trim_enable_q <= 1'b0;
            game_end_q    <= 1'b0;
            lvl_q         <= 3'b000;
            round_q       <= 5'd0;
            answer_q      <= 4'd0;
            score_q       <= 7'd0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            sub_rst_n_q   <= sub_rst_n_d;
            gen_start_q   <= gen_start_d;
            print_start_q <= print_start_d;
            trim_enable_q <= trim_enable_d;
            game_end_q    <= game_end_d;
            lvl_q         <= lvl_d;
            round_q       <= round_d;
            answer_q      <= answer_d;
            score_q       <= score_d;
        end
    end

    // A done seen during its own start pulse belongs to the previous round.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (level_valid && level_ok) state_d = S_CLR;
            S_CLR:    state_d = S_GEN;
            S_GEN:    if (gen_done && !gen_start_q) state_d = S_SHOW;
            S_SHOW:   if (print_done && !print_start_q) state_d = S_INPUT;
            S_INPUT:  if (trim_done) state_d = S_SETTLE;
            S_SETTLE: state_d = S_SAMPLE;
            S_SAMPLE: state_d = last_round ? S_DONE : S_GAP;
            S_GAP:    if (gap_q == GAP_LAST) state_d = S_CLR;
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        sub_rst_n_d   = (state_d != S_CLR);
        gen_start_d   = (state_d == S_GEN) && (state_q != S_GEN);
        print_start_d = (state_d == S_SHOW) && (state_q != S_SHOW);
        trim_enable_d = (state_d == S_INPUT);
        game_end_d    = (state_d == S_DONE);
        gap_d         = (state_q == S_GAP) ? gap_q + GW'(1) : '0;
        lvl_d         = lvl_q;
        round_d       = round_q;
        answer_d      = answer_q;
        score_d       = score_q;
        if (state_q == S_IDLE && state_d == S_CLR) begin
            lvl_d = level;
        end
        if (state_q == S_SAMPLE && round_q < ROUNDS) begin
            round_d  = round_q + 5'd1;
            answer_d = answer_q + {3'b000, round_win};
        end
        if (state_d == S_DONE && state_q != S_DONE) begin
            score_d = STEP * {3'b000, answer_d};
        end
    end

    assign sub_rst_n    = sub_rst_n_q;
    assign gen_start    = gen_start_q;
    assign print_start  = print_start_q;
    assign trim_enable  = trim_enable_q;
    assign level_q      = lvl_q;
    assign round_count  = round_q;
    assign answer_count = answer_q;
    assign score        = score_q;
    assign game_end     = game_end_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: behavioural sub-block responders,
// per-round expectations queued at game start, monitor pops on DUT events.
module tb_round_sequencer;

    localparam int NR   = 10;
    localparam int GAP  = 5;
    localparam int STEP = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       level_valid = 1'b0;
    logic [2:0] level = 3'b000;
    logic       gen_done = 1'b0;
    logic       print_done = 1'b0;
    logic       trim_done = 1'b0;
    logic       round_win = 1'b0;
    logic       sub_rst_n;
    logic       gen_start;
    logic       print_start;
    logic       trim_enable;
    logic [2:0] level_q;
    logic [4:0] round_count;
    logic [3:0] answer_count;
    logic [6:0] score;
    logic       game_end;

    round_sequencer #(
        .NUM_ROUNDS(NR),
        .GAP_CYCLES(GAP),
        .SCORE_STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .level_valid(level_valid),
        .level(level),
        .gen_done(gen_done),
        .print_done(print_done),
        .trim_done(trim_done),
        .round_win(round_win),
        .sub_rst_n(sub_rst_n),
        .gen_start(gen_start),
        .print_start(print_start),
        .trim_enable(trim_enable),
        .level_q(level_q),
        .round_count(round_count),
        .answer_count(answer_count),
        .score(score),
        .game_end(game_end)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sub-block responders: each done rises dly cycles after its start.
    int           dly = 3;
    bit           stale_gen = 1'b0;
    logic [NR-1:0] win_vec = '0;
    int           gcnt = 0;
    int           pcnt = 0;
    int           tcnt = 0;
    logic         tprev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst || !sub_rst_n) begin
                gcnt = 0;
                pcnt = 0;
                tcnt = 0;
                tprev = 1'b0;
                gen_done = stale_gen;
                print_done = 1'b0;
                trim_done = 1'b0;
            end else begin
                if (gen_start) gcnt = dly;
                else if (gcnt > 0) begin
                    gcnt--;
                    if (gcnt == 0) gen_done = 1'b1;
                end
                if (stale_gen) gen_done = 1'b1;
                if (print_start) pcnt = dly;
                else if (pcnt > 0) begin
                    pcnt--;
                    if (pcnt == 0) print_done = 1'b1;
                end
                if (trim_enable && !tprev) tcnt = dly;
                else if (tcnt > 0) begin
                    tcnt--;
                    if (tcnt == 0) trim_done = 1'b1;
                end
                tprev = trim_enable;
            end
            round_win = (round_count < NR) ? win_vec[round_count] : 1'b0;
        end
    end

    typedef struct {
        bit fin;
        int rc;
        int ac;
        int sc;
        int lv;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   prev_rc = 0;
    bit   prev_ge = 1'b0;
    bit   prev_sr = 1'b1;
    int   low_len = 0;
    int   gen_cnt = 0;
    int   clr_cnt = 0;
    int   last_gen = 0;
    bit   gap_armed = 1'b0;
    int   gap_t = 0;

    // Monitor: pops an expectation whenever the DUT reports a finished round.
    initial begin
        forever begin
            @(negedge clk);
            if (gen_start) begin
                gen_cnt++;
                last_gen = cyc;
            end
            if (print_start) chk("gen_to_print", cyc - last_gen, stale_gen ? 2 : dly + 1);
            if (!sub_rst_n) begin
                low_len++;
                if (prev_sr) begin
                    clr_cnt++;
                    if (gap_armed) begin
                        chk("gap_len", cyc - gap_t, GAP);
                        gap_armed = 1'b0;
                    end
                end
            end else if (!prev_sr) begin
                chk("sub_rst_width", low_len, 1);
                low_len = 0;
            end
            prev_sr = sub_rst_n;
            if (round_count != prev_rc && round_count != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_round", round_count, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("item_kind_round", e.fin, 0);
                    chk("round_count", round_count, e.rc);
                    chk("answer_count", answer_count, e.ac);
                    chk("game_end_flag", game_end, e.rc == NR);
                    if (round_count < NR) begin
                        gap_armed = 1'b1;
                        gap_t = cyc;
                    end
                end
            end
            prev_rc = round_count;
            if (game_end && !prev_ge) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", game_end, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("item_kind_final", e.fin, 1);
                    chk("final_score", score, e.sc);
                    chk("final_level_q", level_q, e.lv);
                    chk("gen_start_pulses", gen_cnt, NR);
                    chk("sub_rst_pulses", clr_cnt, NR);
                end
            end
            prev_ge = game_end;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        gen_cnt = 0;
        clr_cnt = 0;
        low_len = 0;
        gap_armed = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sub_rst_n"}, sub_rst_n, 1);
        chk({tag, "_gen_start"}, gen_start, 0);
        chk({tag, "_print_start"}, print_start, 0);
        chk({tag, "_trim_enable"}, trim_enable, 0);
        chk({tag, "_level_q"}, level_q, 0);
        chk({tag, "_round_count"}, round_count, 0);
        chk({tag, "_answer_count"}, answer_count, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_game_end"}, game_end, 0);
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b0;
        level_valid = 1'b0;
        tick();
        check_reset_vals("rst");
        rst = 1'b1;
        tick();
    endtask

    int exp_score = 0;

    task automatic start_game(input logic [2:0] lv, input logic [NR-1:0] wins,
                              input int d, input bit stale);
        exp_t it;
        int acc;
        tick();
        win_vec = wins;
        dly = d;
        stale_gen = stale;
        clear_mon();
        acc = 0;
        for (int i = 0; i < NR; i++) begin
            acc += int'(wins[i]);
            it.fin = 1'b0;
            it.rc = i + 1;
            it.ac = acc;
            it.sc = 0;
            it.lv = 0;
            exp_q.push_back(it);
        end
        exp_score = STEP * acc;
        it.fin = 1'b1;
        it.rc = NR;
        it.ac = acc;
        it.sc = exp_score;
        it.lv = int'(lv);
        exp_q.push_back(it);
        level = lv;
        level_valid = 1'b1;
        @(negedge clk);
        chk("no_clr_before_edge", sub_rst_n, 1);
        tick();
        chk("clr_after_start", sub_rst_n, 0);
        chk("level_latched", level_q, lv);
        chk("no_gen_in_clr", gen_start, 0);
        tick();
        chk("gen_start_2cyc", gen_start, 1);
        level = (lv == 3'b001) ? 3'b010 : 3'b001;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (game_end) seen = 1'b1;
        end
        chk("game_end_reached", seen, 1);
        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        chk("game_end_hold", game_end, 1);
        chk("round_count_hold", round_count, NR);
        chk("score_hold", score, exp_score);
        exp_q.delete();
    endtask

    initial begin
        int bad;
        bit hit;
        rst = 1'b0;
        tick();
        tick();
        check_reset_vals("init");
        rst = 1'b1;
        tick();

        level_valid = 1'b1;
        level = 3'b011;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!sub_rst_n || gen_start || level_q != 3'b000) bad++;
        end
        chk("invalid_011_idle", bad, 0);
        level = 3'b000;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (!sub_rst_n || gen_start || level_q != 3'b000) bad++;
        end
        chk("invalid_000_idle", bad, 0);

        start_game(3'b001, NR'($urandom), 2, 1'b0);
        wait_end();

        reset_dut();
        start_game(3'b010, {NR{1'b1}}, 3, 1'b0);
        wait_end();

        reset_dut();
        start_game(3'b100, 10'b0001001001, 1, 1'b0);
        wait_end();

        reset_dut();
        start_game(3'b010, NR'($urandom), 2, 1'b1);
        wait_end();

        reset_dut();
        start_game(3'b100, NR'($urandom), $urandom_range(1, 4), 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            @(negedge clk);
            if (round_count == 5'd3 && trim_enable) hit = 1'b1;
        end
        chk("reached_round4_input", hit, 1);
        rst = 1'b0;
        level_valid = 1'b0;
        tick();
        check_reset_vals("midrst");
        exp_q.delete();
        clear_mon();
        rst = 1'b1;
        tick();

        start_game(3'b001, NR'($urandom), $urandom_range(1, 4), 1'b0);
        wait_end();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
